// File: rtl/ddr4_rd_checker_if.sv
// MIG application read-data return path: one 512-bit beat per valid cycle, no backpressure.
interface ddr4_rd_checker_if #(
    parameter int NUM_WORDS = 16
);
    logic                      c0_ddr4_app_rd_data_valid;
    logic [NUM_WORDS*32-1:0]   c0_ddr4_app_rd_data;

    modport master (
        output c0_ddr4_app_rd_data_valid,
        output c0_ddr4_app_rd_data
    );

    modport slave (
        input  c0_ddr4_app_rd_data_valid,
        input  c0_ddr4_app_rd_data
    );
endinterface

// File: rtl/ddr4_rd_checker.sv
// Read-data checker: regenerates the traffic-controller write pattern for every returned beat,
// compares it per 32-bit word through a two-stage pipeline and accumulates statistics.
module ddr4_rd_checker #(
    parameter int NUM_WORDS = 16,
    parameter int CNT_W     = 32
) (
    input  logic                  c0_ddr4_ui_clk,
    input  logic                  rst,
    input  logic                  chk_start,
    input  logic                  chk_xor_en,
    input  logic [31:0]           chk_wdata_base,
    input  logic [30:0]           chk_num_beats,
    ddr4_rd_checker_if.slave      rd,
    output logic                  chk_busy,
    output logic                  chk_done,
    output logic [CNT_W-1:0]      chk_beat_cnt,
    output logic [CNT_W-1:0]      chk_err_beats,
    output logic [CNT_W-1:0]      chk_err_words,
    output logic                  chk_first_err_valid,
    output logic [30:0]           chk_first_err_beat,
    output logic [NUM_WORDS-1:0]  chk_first_err_mask,
    output logic [CNT_W-1:0]      chk_stray_cnt
);
    localparam int DW = NUM_WORDS * 32;
    localparam int PW = $clog2(NUM_WORDS + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]           state_reg, state_next;
    logic [31:0]          base_reg;
    logic                 xor_en_reg;
    logic [30:0]          num_beats_reg;
    logic [30:0]          beat_idx_reg;

    logic                 a_valid_reg;
    logic [DW-1:0]        a_data_reg;
    logic [30:0]          a_idx_reg;

    logic                 b_valid_reg;
    logic [NUM_WORDS-1:0] b_mask_reg;
    logic [PW-1:0]        b_pop_reg;
    logic [30:0]          b_idx_reg;

    logic [CNT_W-1:0]     beat_cnt_reg, err_beats_reg, err_words_reg, stray_cnt_reg;
    logic                 first_valid_reg;
    logic [30:0]          first_beat_reg;
    logic [NUM_WORDS-1:0] first_mask_reg;

    logic                 in_range, accept, stray, last_update;
    logic [NUM_WORDS-1:0] mask_next;
    logic [PW-1:0]        pop_next;
    logic [CNT_W:0]       err_words_sum;
    logic [CNT_W-1:0]     err_words_next, err_beats_next, stray_cnt_next;

    // A beat coincident with chk_start belongs to neither the old nor the new run.
    assign in_range    = beat_idx_reg < num_beats_reg;
    assign accept      = rd.c0_ddr4_app_rd_data_valid && !chk_start && (state_reg == ST_RUN) && in_range;
    assign stray       = rd.c0_ddr4_app_rd_data_valid && !chk_start && !((state_reg == ST_RUN) && in_range);
    assign last_update = b_valid_reg && (b_idx_reg == num_beats_reg - 31'd1);

    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
            localparam logic [3:0] WIDX = 4'(gi);
            logic [31:0] exp_word;
            assign exp_word      = xor_en_reg ? (base_reg ^ {a_idx_reg[23:0], 4'h0, WIDX}) : base_reg;
            assign mask_next[gi] = a_data_reg[gi*32 +: 32] != exp_word;
        end
    endgenerate

    always_comb begin
        pop_next = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            pop_next = pop_next + PW'(mask_next[i]);
        end
    end

    // Error and stray counters stick at all-ones instead of wrapping.
    assign err_words_sum  = {1'b0, err_words_reg} + (CNT_W+1)'(b_pop_reg);
    assign err_words_next = err_words_sum[CNT_W] ? {CNT_W{1'b1}} : err_words_sum[CNT_W-1:0];
    assign err_beats_next = (err_beats_reg == {CNT_W{1'b1}}) ? err_beats_reg : err_beats_reg + 1'b1;
    assign stray_cnt_next = (stray_cnt_reg == {CNT_W{1'b1}}) ? stray_cnt_reg : stray_cnt_reg + 1'b1;

    always_comb begin
        state_next = state_reg;
        if (chk_start) begin
            state_next = (chk_num_beats == 31'd0) ? ST_DONE : ST_RUN;
        end else if ((state_reg == ST_RUN) && last_update) begin
            state_next = ST_DONE;
        end
    end

    always_ff @(posedge c0_ddr4_ui_clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            base_reg      <= '0;
            xor_en_reg    <= 1'b0;
            num_beats_reg <= '0;
            beat_idx_reg  <= '0;
            a_valid_reg   <= 1'b0;
            a_data_reg    <= '0;
            a_idx_reg     <= '0;
            b_valid_reg   <= 1'b0;
            b_mask_reg    <= '0;
            b_pop_reg     <= '0;
            b_idx_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (chk_start) begin
                base_reg      <= chk_wdata_base;
                xor_en_reg    <= chk_xor_en;
                num_beats_reg <= chk_num_beats;
                beat_idx_reg  <= '0;
                a_valid_reg   <= 1'b0;
                b_valid_reg   <= 1'b0;
            end else begin
                a_valid_reg <= accept;
                if (accept) begin
                    a_data_reg   <= rd.c0_ddr4_app_rd_data;
                    a_idx_reg    <= beat_idx_reg;
                    beat_idx_reg <= beat_idx_reg + 31'd1;
                end
                b_valid_reg <= a_valid_reg;
                if (a_valid_reg) begin
                    b_mask_reg <= mask_next;
                    b_pop_reg  <= pop_next;
                    b_idx_reg  <= a_idx_reg;
                end
            end
        end
    end

    always_ff @(posedge c0_ddr4_ui_clk) begin
        if (rst || chk_start) begin
            beat_cnt_reg    <= '0;
            err_beats_reg   <= '0;
            err_words_reg   <= '0;
            stray_cnt_reg   <= '0;
            first_valid_reg <= 1'b0;
            first_beat_reg  <= '0;
            first_mask_reg  <= '0;
        end else begin
            if (b_valid_reg) begin
                beat_cnt_reg <= beat_cnt_reg + 1'b1;
                if (b_mask_reg != '0) begin
                    err_beats_reg <= err_beats_next;
                    err_words_reg <= err_words_next;
                    if (!first_valid_reg) begin
                        first_valid_reg <= 1'b1;
                        first_beat_reg  <= b_idx_reg;
                        first_mask_reg  <= b_mask_reg;
                    end
                end
            end
            if (stray) begin
                stray_cnt_reg <= stray_cnt_next;
            end
        end
    end

    assign chk_busy            = (state_reg == ST_RUN);
    assign chk_done            = (state_reg == ST_DONE);
    assign chk_beat_cnt        = beat_cnt_reg;
    assign chk_err_beats       = err_beats_reg;
    assign chk_err_words       = err_words_reg;
    assign chk_first_err_valid = first_valid_reg;
    assign chk_first_err_beat  = first_beat_reg;
    assign chk_first_err_mask  = first_mask_reg;
    assign chk_stray_cnt       = stray_cnt_reg;
endmodule

// File: tb/tb_ddr4_rd_checker.sv
// Directed plus randomized bench for ddr4_rd_checker; expected statistics come from a
// word-by-word comparison of each sent beat against the pattern rule.
module tb_ddr4_rd_checker;
    localparam int NW = 16;
    localparam int CW = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           chk_start = 1'b0;
    logic           chk_xor_en = 1'b0;
    logic [31:0]    chk_wdata_base = '0;
    logic [30:0]    chk_num_beats = '0;
    logic           chk_busy, chk_done, chk_first_err_valid;
    logic [CW-1:0]  chk_beat_cnt, chk_err_beats, chk_err_words, chk_stray_cnt;
    logic [30:0]    chk_first_err_beat;
    logic [NW-1:0]  chk_first_err_mask;

    int errors = 0;
    int checks = 0;

    ddr4_rd_checker_if #(.NUM_WORDS(NW)) rd_bus ();

    ddr4_rd_checker #(.NUM_WORDS(NW), .CNT_W(CW)) dut (
        .c0_ddr4_ui_clk      (clk),
        .rst                 (rst),
        .chk_start           (chk_start),
        .chk_xor_en          (chk_xor_en),
        .chk_wdata_base      (chk_wdata_base),
        .chk_num_beats       (chk_num_beats),
        .rd                  (rd_bus.slave),
        .chk_busy            (chk_busy),
        .chk_done            (chk_done),
        .chk_beat_cnt        (chk_beat_cnt),
        .chk_err_beats       (chk_err_beats),
        .chk_err_words       (chk_err_words),
        .chk_first_err_valid (chk_first_err_valid),
        .chk_first_err_beat  (chk_first_err_beat),
        .chk_first_err_mask  (chk_first_err_mask),
        .chk_stray_cnt       (chk_stray_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int unsigned n, input int w,
                                             input logic [31:0] base, input logic x);
        logic [31:0] pat;
        pat = (n % 32'h0100_0000) * 256 + w;
        return x ? (base ^ pat) : base;
    endfunction

    function automatic logic [NW*32-1:0] good_beat(input int unsigned n, input logic [31:0] base,
                                                   input logic x);
        logic [NW*32-1:0] d;
        for (int w = 0; w < NW; w++) d[w*32 +: 32] = exp_word(n, w, base, x);
        return d;
    endfunction

    task automatic start(input logic [31:0] base, input logic x, input logic [30:0] nb);
        chk_start = 1'b1; chk_wdata_base = base; chk_xor_en = x; chk_num_beats = nb;
        tick();
        chk_start = 1'b0;
        $display("start base=%h xor=%0d num_beats=%0d", base, x, nb);
    endtask

    task automatic send(input logic [NW*32-1:0] d);
        rd_bus.c0_ddr4_app_rd_data_valid = 1'b1;
        rd_bus.c0_ddr4_app_rd_data       = d;
        tick();
        rd_bus.c0_ddr4_app_rd_data_valid = 1'b0;
        $display("beat word0=%h word15=%h", d[31:0], d[NW*32-1 -: 32]);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 40 && !chk_done; k++) tick();
        check("done_wait", 64'(chk_done), 64'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},   64'(chk_busy), 0);
        check({tag, "_done"},   64'(chk_done), 0);
        check({tag, "_beats"},  64'(chk_beat_cnt), 0);
        check({tag, "_eb"},     64'(chk_err_beats), 0);
        check({tag, "_ew"},     64'(chk_err_words), 0);
        check({tag, "_fv"},     64'(chk_first_err_valid), 0);
        check({tag, "_fb"},     64'(chk_first_err_beat), 0);
        check({tag, "_fm"},     64'(chk_first_err_mask), 0);
        check({tag, "_stray"},  64'(chk_stray_cnt), 0);
    endtask

    initial begin
        logic [NW*32-1:0] d;
        rd_bus.c0_ddr4_app_rd_data_valid = 1'b0;
        rd_bus.c0_ddr4_app_rd_data       = '0;

        // Reset state
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        check_zero("reset");

        // Four clean beats, done exactly 3 cycles after the last valid
        start(32'hA5A50000, 1'b1, 31'd4);
        check("t1_busy", 64'(chk_busy), 1);
        for (int b = 0; b < 4; b++) send(good_beat(b, 32'hA5A50000, 1'b1));
        check("t1_done_t1", 64'(chk_done), 0);
        tick();
        check("t1_done_t2", 64'(chk_done), 0);
        tick();
        check("t1_done_t3", 64'(chk_done), 1);
        check("t1_busy_end", 64'(chk_busy), 0);
        check("t1_beats", 64'(chk_beat_cnt), 4);
        check("t1_eb", 64'(chk_err_beats), 0);
        check("t1_ew", 64'(chk_err_words), 0);
        check("t1_fv", 64'(chk_first_err_valid), 0);

        // Beat 3 with words 5 and 9 corrupted
        start(32'hA5A50000, 1'b1, 31'd4);
        for (int b = 0; b < 4; b++) begin
            d = good_beat(b, 32'hA5A50000, 1'b1);
            if (b == 3) begin
                d[5*32 +: 32] = 32'hA5A50304;
                d[9*32 +: 32] = d[9*32 +: 32] ^ 32'h0000_8000;
            end
            send(d);
        end
        tick(); tick();
        check("t2_done", 64'(chk_done), 1);
        check("t2_eb", 64'(chk_err_beats), 1);
        check("t2_ew", 64'(chk_err_words), 2);
        check("t2_fv", 64'(chk_first_err_valid), 1);
        check("t2_fb", 64'(chk_first_err_beat), 3);
        check("t2_fm", 64'(chk_first_err_mask), 64'h0220);

        // Plain base pattern; two fully wrong beats, first error must stick to beat 0
        start(32'h12345678, 1'b0, 31'd2);
        send('0);
        send({NW{~32'h12345678}});
        wait_done();
        check("t3_eb", 64'(chk_err_beats), 2);
        check("t3_ew", 64'(chk_err_words), 32);
        check("t3_fb", 64'(chk_first_err_beat), 0);
        check("t3_fm", 64'(chk_first_err_mask), 64'hFFFF);

        // Strays from IDLE, cleared by start, then overrun strays in the new run
        rst = 1'b1; tick(); rst = 1'b0;
        send(good_beat(0, 32'h0, 1'b0));
        send(good_beat(0, 32'h0, 1'b0));
        check("s_idle_stray", 64'(chk_stray_cnt), 2);
        start(32'hCAFE0000, 1'b1, 31'd1);
        check("s_start_clear", 64'(chk_stray_cnt), 0);
        for (int b = 0; b < 3; b++) send(good_beat(b, 32'hCAFE0000, 1'b1));
        wait_done();
        check("s_beats", 64'(chk_beat_cnt), 1);
        check("s_stray", 64'(chk_stray_cnt), 2);
        check("s_ew", 64'(chk_err_words), 0);
        send(good_beat(0, 32'h0, 1'b0));
        check("s_done_stray", 64'(chk_stray_cnt), 3);

        // Restart with two bad beats in flight and a beat coincident with start
        start(32'h11110000, 1'b1, 31'd4);
        send('1);
        send('1);
        chk_start = 1'b1; chk_wdata_base = 32'h22220000; chk_xor_en = 1'b1; chk_num_beats = 31'd2;
        rd_bus.c0_ddr4_app_rd_data_valid = 1'b1;
        rd_bus.c0_ddr4_app_rd_data       = '1;
        tick();
        chk_start = 1'b0;
        rd_bus.c0_ddr4_app_rd_data_valid = 1'b0;
        $display("restart base=22220000 with coincident beat");
        tick(); tick();
        check("r_flush_beats", 64'(chk_beat_cnt), 0);
        check("r_flush_ew", 64'(chk_err_words), 0);
        check("r_flush_stray", 64'(chk_stray_cnt), 0);
        check("r_busy", 64'(chk_busy), 1);
        send(good_beat(0, 32'h22220000, 1'b1));
        send(good_beat(1, 32'h22220000, 1'b1));
        wait_done();
        check("r_beats", 64'(chk_beat_cnt), 2);
        check("r_ew", 64'(chk_err_words), 0);

        // Reset mid-run with errored beats in flight
        start(32'h0, 1'b1, 31'd8);
        send('1); send('1); send('1);
        rst = 1'b1; tick(); rst = 1'b0;
        check_zero("rst_mid");
        tick(); tick(); tick();
        check_zero("rst_after");

        // Zero-beat run completes on the next cycle
        start(32'h5, 1'b0, 31'd0);
        check("z_done", 64'(chk_done), 1);
        check("z_busy", 64'(chk_busy), 0);
        check("z_beats", 64'(chk_beat_cnt), 0);

        // Randomized runs against the word-compare model
        for (int it = 0; it < 4; it++) begin
            logic [31:0]   base;
            logic          x;
            int            nb, extra, m_eb, m_ew, m_fb;
            logic [NW-1:0] m_fm, mask;
            base  = $urandom;
            x     = 1'($urandom_range(0, 1));
            nb    = $urandom_range(3, 12);
            extra = $urandom_range(0, 2);
            m_eb = 0; m_ew = 0; m_fb = -1; m_fm = '0;
            start(base, x, 31'(nb));
            for (int b = 0; b < nb + extra; b++) begin
                d = good_beat(b, base, x);
                for (int w = 0; w < NW; w++)
                    if ($urandom_range(0, 7) == 0) d[w*32 +: 32] = d[w*32 +: 32] ^ ($urandom | 32'h1);
                if (b < nb) begin
                    mask = '0;
                    for (int w = 0; w < NW; w++) mask[w] = (d[w*32 +: 32] != exp_word(b, w, base, x));
                    if (mask != '0) begin
                        m_eb++;
                        m_ew += $countones(mask);
                        if (m_fb < 0) begin m_fb = b; m_fm = mask; end
                    end
                    for (int g = $urandom_range(0, 2); g > 0; g--) tick();
                end
                send(d);
            end
            wait_done();
            check("rnd_beats", 64'(chk_beat_cnt), 64'(nb));
            check("rnd_eb", 64'(chk_err_beats), 64'(m_eb));
            check("rnd_ew", 64'(chk_err_words), 64'(m_ew));
            check("rnd_stray", 64'(chk_stray_cnt), 64'(extra));
            check("rnd_fv", 64'(chk_first_err_valid), 64'(m_fb >= 0));
            if (m_fb >= 0) begin
                check("rnd_fb", 64'(chk_first_err_beat), 64'(m_fb));
                check("rnd_fm", 64'(chk_first_err_mask), 64'(m_fm));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ddr4_rd_checker.md
Name: ddr4_rd_checker

Overview:
- Read-data checker placed directly downstream of the DDR4 traffic controller. It consumes the MIG app read-data return path (c0_ddr4_app_rd_data / _valid).
- For every returned 512-bit beat it regenerates the expected pattern using the same rule the traffic controller uses to write. The pattern is the base word, optionally XORed with the beat index and word index.
- Results are compared per 32-bit word. Statistics and the first failure are exported to the loop register block.
- The block runs entirely in the c0_ddr4_ui_clk domain.

Parameters:
NUM_WORDS, 16, number of 32-bit words per beat; data width = NUM_WORDS*32 (512).
CNT_W, 32, width of the beat, error and stray counters.

Ports:
c0_ddr4_ui_clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
chk_start  in  1  one-cycle pulse; arms the checker and clears all statistics.
chk_xor_en  in  1  1 = expected word i of beat n = {n[23:0],4'h0,i[3:0]} ^ chk_wdata_base; 0 = chk_wdata_base.
chk_wdata_base  in  32  pattern base word; sampled on chk_start.
chk_num_beats  in  31  number of beats expected; sampled on chk_start.
c0_ddr4_app_rd_data_valid  in  1  read beat valid.
c0_ddr4_app_rd_data  in  512  read beat data.
chk_busy  out  1  state == RUN.
chk_done  out  1  state == DONE.
chk_beat_cnt  out  CNT_W  beats checked since start.
chk_err_beats  out  CNT_W  beats with at least one mismatching word; saturating.
chk_err_words  out  CNT_W  total mismatching 32-bit words; saturating.
chk_first_err_valid  out  1  a first error has been captured.
chk_first_err_beat  out  31  beat index of the first failing beat.
chk_first_err_mask  out  NUM_WORDS  word-mismatch mask of the first failing beat (bit i = word i).
chk_stray_cnt  out  CNT_W  beats received while not in RUN; saturating.

Behaviour:
- Reset: all outputs 0; state IDLE; pipeline valids 0; sampled config 0. Reset mid-run aborts immediately, and nothing survives it.
- States:
  - IDLE. On chk_start: if chk_num_beats == 0 go to DONE, otherwise go to RUN.
  - RUN. Go to DONE on the edge where the final stats update occurs for beat index num_beats-1.
  - DONE. On chk_start go to RUN, or to DONE again if num_beats == 0.
  - chk_start in RUN restarts.
- chk_start (any state):
  - samples base, xor_en and num_beats;
  - zeroes beat_cnt, err_beats, err_words, stray_cnt, first_err_* and the beat index;
  - flushes both pipeline stage valids.
  - A read beat presented in the same cycle as chk_start is dropped: it is neither checked nor counted as stray.
- Pipeline, for a beat presented in cycle T while in RUN:
  - Stage A (registered end of T): data, valid, beat index n. The index counter then increments and wraps at 2^31.
  - Stage B (registered end of T+1): 16-bit mismatch mask and popcount. The expected value uses the sampled config and n.
  - Stats (registered end of T+2): visible in cycle T+3.
- Stats update rules:
  - beat_cnt += 1.
  - If mask != 0: err_beats += 1 and err_words += popcount(mask).
  - Error counters saturate at all-ones and never wrap.
- First error:
  - Captured only while first_err_valid == 0; it holds until the next chk_start or rst.
  - mask and beat are registered in the same edge as the stats update.
- Beats presented in cycle T while in IDLE or DONE: stray_cnt += 1 at end of T; they are not compared.
- A beat accepted in RUN whose index is >= num_beats (an overrun beyond the expected count) is counted as stray, not compared.
- Beats already in the pipeline when RUN→DONE occurs still complete their stats update. They are in-range by construction.
- Back-to-back valid beats are accepted every cycle with no stall. The MIG has no backpressure on read data.
- chk_done therefore rises in cycle T_last+3, together with the final counts.
- Only XOR pattern bits n[23:0] are used; the index itself is 31 bits.

Test Plan:
- Setup: rst; num_beats=4, xor=1, base=0xA5A50000; start; 4 correct beats on consecutive cycles.
  -> beat_cnt=4, err_beats=0, err_words=0, first_err_valid=0; done=1 exactly 3 cycles after the 4th valid; busy=0.
- Same setup, but beat 3 word 5 is corrupted (expected 0xA5A50305, sent 0xA5A50304), and beat 3 word 9 is also wrong.
  -> err_beats=1, err_words=2, first_err_beat=3, first_err_mask=0x0220.
- Setup: xor=0, base=0x12345678, num_beats=2; beat0 all words 0; beat1 all words wrong.
  -> err_beats=2, err_words=32, first_err_beat=0, first_err_mask=0xFFFF; the second error does not overwrite the first.
- 2 beats before start, then num_beats=1 with 3 beats after start.
  -> stray_cnt counts only the 2 overrun beats after the restart clear: beat_cnt=1, stray_cnt=2.
  - Repeat with the prior-IDLE case: stray=2 before start, cleared to 0 on start.
- Restart check: chk_start mid-run with 2 beats in flight, and a valid beat in the same cycle as start.
  -> in-flight beats are flushed; counts restart at 0; the coincident beat is not counted.
- Reset check: rst during RUN -> all outputs 0 next cycle. Also: num_beats=0 + start -> done=1 the next cycle, beat_cnt=0.
